snake_frame_scheduler: RTL and testbench



---
 rtl/snake_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_snake_frame_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_scheduler.sv
// Frame-locked step scheduler for the snake game: turns VSync into step requests,
// commits the player direction per step and speeds up as food is eaten.
// Optional step-acknowledge timeout: define SNAKE_STEP_TIMEOUT_EN.
module snake_frame_scheduler #(
  parameter int unsigned c_FRAMES_PER_STEP     = 8,
  parameter int unsigned c_MIN_FRAMES_PER_STEP = 2,
  parameter int unsigned c_SPEEDUP_EVERY       = 4,
  parameter logic        c_VSYNC_POL           = 1'b1,
  parameter int unsigned c_STEP_TIMEOUT        = 1024
) (
  input  logic                                   i_Clk,
  input  logic                                   i_Rst,
  input  logic                                   i_VSync,
  input  logic                                   i_Start,
  input  logic [1:0]                             i_Dir,
  input  logic                                   i_DirValid,
  input  logic                                   i_StepDone,
  input  logic                                   i_Ate,
  input  logic                                   i_GameOver,
  output logic                                   o_Step,
  output logic [1:0]                             o_Dir,
  output logic                                   o_Playing,
  output logic [$clog2(c_FRAMES_PER_STEP+1)-1:0] o_Period,
  output logic                                   o_Timeout
);

  localparam int unsigned PeriodW = $clog2(c_FRAMES_PER_STEP + 1);
  localparam int unsigned EatW    = $clog2(c_SPEEDUP_EVERY + 1);

  localparam logic [PeriodW-1:0] PeriodInit = PeriodW'(c_FRAMES_PER_STEP);
  localparam logic [PeriodW-1:0] PeriodMin  = PeriodW'(c_MIN_FRAMES_PER_STEP);
  localparam logic [EatW-1:0]    EatLast    = EatW'(c_SPEEDUP_EVERY - 1);
  localparam logic [1:0]         DirRight   = 2'd1;

  typedef enum logic [1:0] {StIdle, StWaitFrame, StStepWait, StOver} state_e;

  state_e             state_q, state_d;
  logic               vsync_q, vsync_prev_q;
  logic               frame_start;
  logic               playing;
  logic [PeriodW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [EatW-1:0]    eat_cnt_q, eat_cnt_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         pend_dir_q, pend_dir_d;
  logic               step_q, step_d;

`ifdef SNAKE_STEP_TIMEOUT_EN
  localparam int unsigned ToW    = $clog2(c_STEP_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(c_STEP_TIMEOUT - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  assign frame_start = (vsync_q == c_VSYNC_POL) && (vsync_prev_q != c_VSYNC_POL);
  assign playing     = (state_q == StWaitFrame) || (state_q == StStepWait);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    period_d    = period_q;
    eat_cnt_d   = eat_cnt_q;
    dir_d       = dir_q;
    pend_dir_d  = pend_dir_q;
    step_d      = step_q;
`ifdef SNAKE_STEP_TIMEOUT_EN
    to_cnt_d    = '0;
    timeout_d   = 1'b0;
`endif

    // Reversal is judged against the committed direction, not the pending one.
    if (i_DirValid && (i_Dir != (dir_q ^ 2'b10))) begin
      pend_dir_d = i_Dir;
    end

    if (playing && i_Ate) begin
      if (eat_cnt_q == EatLast) begin
        eat_cnt_d = '0;
        if (period_q > PeriodMin) begin
          period_d = period_q - PeriodW'(1);
        end
      end else begin
        eat_cnt_d = eat_cnt_q + EatW'(1);
      end
    end

    unique case (state_q)
      StIdle, StOver: begin
        step_d = 1'b0;
        if (i_Start) begin
          period_d    = PeriodInit;
          dir_d       = DirRight;
          pend_dir_d  = DirRight;
          frame_cnt_d = '0;
          eat_cnt_d   = '0;
          state_d     = StWaitFrame;
        end
      end
      StWaitFrame: begin
        if (i_GameOver) begin
          state_d = StOver;
        end else if (frame_start) begin
          // >= so that a period shrink below the current count fires at once.
          if (frame_cnt_q >= period_q - PeriodW'(1)) begin
            frame_cnt_d = '0;
            dir_d       = pend_dir_q;
            step_d      = 1'b1;
            state_d     = StStepWait;
          end else begin
            frame_cnt_d = frame_cnt_q + PeriodW'(1);
          end
        end
      end
      StStepWait: begin
        if (i_StepDone) begin
          step_d  = 1'b0;
          state_d = i_GameOver ? StOver : StWaitFrame;
        end
`ifdef SNAKE_STEP_TIMEOUT_EN
        else if (to_cnt_q == ToLast) begin
          step_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StOver;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      vsync_q      <= ~c_VSYNC_POL;
      vsync_prev_q <= ~c_VSYNC_POL;
      frame_cnt_q  <= '0;
      period_q     <= PeriodInit;
      eat_cnt_q    <= '0;
      dir_q        <= DirRight;
      pend_dir_q   <= DirRight;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= i_VSync;
      vsync_prev_q <= vsync_q;
      frame_cnt_q  <= frame_cnt_d;
      period_q     <= period_d;
      eat_cnt_q    <= eat_cnt_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      step_q       <= step_d;
    end
  end

`ifdef SNAKE_STEP_TIMEOUT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Timeout = timeout_q;
`else
  assign o_Timeout = 1'b0;
`endif

  assign o_Step    = step_q;
  assign o_Dir     = dir_q;
  assign o_Playing = playing;
  assign o_Period  = period_q;

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// Scoreboard bench for snake_frame_scheduler: expected steps are queued with the
// frame number, committed direction and period; a monitor checks each o_Step rise.
module tb_snake_frame_scheduler;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_VSync = 1'b0;
  logic       i_Start = 1'b0;
  logic [1:0] i_Dir = 2'd0;
  logic       i_DirValid = 1'b0;
  logic       i_StepDone = 1'b0;
  logic       i_Ate = 1'b0;
  logic       i_GameOver = 1'b0;
  logic       o_Step;
  logic [1:0] o_Dir;
  logic       o_Playing;
  logic [3:0] o_Period;
  logic       o_Timeout;

  snake_frame_scheduler #(
    .c_FRAMES_PER_STEP    (8),
    .c_MIN_FRAMES_PER_STEP(2),
    .c_SPEEDUP_EVERY      (4),
    .c_VSYNC_POL          (1'b1),
    .c_STEP_TIMEOUT       (16)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_VSync   (i_VSync),
    .i_Start   (i_Start),
    .i_Dir     (i_Dir),
    .i_DirValid(i_DirValid),
    .i_StepDone(i_StepDone),
    .i_Ate     (i_Ate),
    .i_GameOver(i_GameOver),
    .o_Step    (o_Step),
    .o_Dir     (o_Dir),
    .o_Playing (o_Playing),
    .o_Period  (o_Period),
    .o_Timeout (o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int frame;
    int dir;
    int period;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_n = 0;
  bit   ack_en = 1'b1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_step(input int frames_ahead, input int dir, input int period);
    exp_t e;
    e.frame  = frame_n + frames_ahead;
    e.dir    = dir;
    e.period = period;
    exp_q.push_back(e);
  endtask

  task automatic frame_pulse();
    i_VSync = 1'b1;
    frame_n++;
    repeat (4) @(negedge i_Clk);
    i_VSync = 1'b0;
    repeat (20) @(negedge i_Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  task automatic start_pulse();
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    @(negedge i_Clk);
  endtask

  task automatic ate_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_Ate = 1'b1;
      @(negedge i_Clk);
      i_Ate = 1'b0;
      @(negedge i_Clk);
    end
  endtask

  task automatic dir_input(input logic [1:0] d);
    i_Dir      = d;
    i_DirValid = 1'b1;
    @(negedge i_Clk);
    i_DirValid = 1'b0;
    @(negedge i_Clk);
  endtask

  task automatic wait_step(input string name);
    int n = 0;
    while (!o_Step && n < 60) begin
      @(negedge i_Clk);
      n++;
    end
    check(name, int'(o_Step), 1);
  endtask

  // Game-logic model: acknowledge each step a few cycles after it rises.
  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_Step === 1'b1 && ack_en) begin
        repeat (2) @(negedge i_Clk);
        i_StepDone = 1'b1;
        @(negedge i_Clk);
        i_StepDone = 1'b0;
      end
    end
  end

  // Monitor: every o_Step rise must match the head of the scoreboard.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge i_Clk);
      if (o_Step === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: o_Step rose at frame %0d, required no step", frame_n);
        end else begin
          e = exp_q.pop_front();
          check("step_frame", frame_n, e.frame);
          check("step_dir", int'(o_Dir), e.dir);
          check("step_period", int'(o_Period), e.period);
        end
      end
      prev = (o_Step === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    // Reset state
    check("rst_step", int'(o_Step), 0);
    check("rst_dir", int'(o_Dir), 1);
    check("rst_playing", int'(o_Playing), 0);
    check("rst_timeout", int'(o_Timeout), 0);
    check("rst_period", int'(o_Period), 8);

    // Basic stepping: 20 frames at period 8 -> steps after frames 8 and 16
    start_pulse();
    check("start_playing", int'(o_Playing), 1);
    expect_step(8, 1, 8);
    expect_step(16, 1, 8);
    frames(20);
    check("run_playing", int'(o_Playing), 1);
    check("run_dir", int'(o_Dir), 1);

    // Speed-up: frame count is 4 here; period 8 -> 7, then saturate at 2
    ate_pulses(4);
    check("speedup_7", int'(o_Period), 7);
    ate_pulses(28);
    check("speedup_sat", int'(o_Period), 2);
    expect_step(1, 1, 2);
    expect_step(3, 1, 2);
    expect_step(5, 1, 2);
    frames(5);

    // Direction: 3 is a reversal of 1 and dropped; last accepted (2) wins
    dir_input(2'd3);
    dir_input(2'd0);
    dir_input(2'd2);
    dir_input(2'd3);
    expect_step(2, 2, 2);
    frames(2);
    check("dir_committed", int'(o_Dir), 2);
    dir_input(2'd0);
    expect_step(2, 2, 2);
    frames(2);

    // Game over raised together with the step acknowledge
    expect_step(2, 2, 2);
    frame_pulse();
    fork
      frame_pulse();
      begin
        wait_step("over_step_rise");
        i_GameOver = 1'b1;
      end
    join
    check("over_playing", int'(o_Playing), 0);
    check("over_step", int'(o_Step), 0);
    i_GameOver = 1'b0;
    frames(4);
    check("over_no_step", int'(o_Step), 0);
    start_pulse();
    check("restart_period", int'(o_Period), 8);
    check("restart_dir", int'(o_Dir), 1);
    check("restart_playing", int'(o_Playing), 1);
    expect_step(8, 1, 8);
    frames(8);

    // Reset while a step awaits acknowledge
    ack_en = 1'b0;
    dir_input(2'd0);
    ate_pulses(4);
    check("pre_rst_period", int'(o_Period), 7);
    expect_step(7, 0, 7);
    frames(6);
    fork
      frame_pulse();
      begin
        wait_step("rst_step_rise");
        repeat (3) @(negedge i_Clk);
        check("rst_wait_step", int'(o_Step), 1);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        check("midrst_step", int'(o_Step), 0);
        check("midrst_dir", int'(o_Dir), 1);
        check("midrst_period", int'(o_Period), 8);
        check("midrst_playing", int'(o_Playing), 0);
        check("midrst_timeout", int'(o_Timeout), 0);
        i_Rst = 1'b0;
      end
    join
    frames(2);
    check("idle_no_step", int'(o_Step), 0);

    // Unacknowledged step
    start_pulse();
    expect_step(8, 1, 8);
    frames(7);
`ifdef SNAKE_STEP_TIMEOUT_EN
    fork
      frame_pulse();
      begin
        wait_step("to_step_rise");
        k = 0;
        while (!o_Timeout && k < 40) begin
          @(negedge i_Clk);
          k++;
        end
        check("timeout_latency", k, 16);
        check("timeout_step", int'(o_Step), 0);
        check("timeout_playing", int'(o_Playing), 0);
        @(negedge i_Clk);
        check("timeout_pulse_len", int'(o_Timeout), 0);
      end
    join
`else
    fork
      frame_pulse();
      begin
        wait_step("hold_step_rise");
        k = 0;
        repeat (30) begin
          @(negedge i_Clk);
          if (o_Timeout !== 1'b0) k++;
        end
        check("hold_step", int'(o_Step), 1);
        check("hold_no_timeout", k, 0);
        i_StepDone = 1'b1;
        @(negedge i_Clk);
        i_StepDone = 1'b0;
        @(negedge i_Clk);
        check("hold_ack_step", int'(o_Step), 0);
      end
    join
`endif
    ack_en = 1'b1;

    check("all_steps_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
